// File: rtl/div_seq.sv
// Multi-cycle restoring divider: quotient on low, remainder on hi, one quotient bit per cycle.
// Supports signed/unsigned operands and flags divide-by-zero; start/busy/done handshake.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divInit,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] value_A,
  input  logic [WIDTH-1:0] value_B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] low,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StZero} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     trial;

  // The magnitude of MIN is MIN itself, which is exactly 2^(WIDTH-1) when read unsigned.
  assign a_mag = (is_signed && value_A[WIDTH-1]) ? -value_A : value_A;
  assign b_mag = (is_signed && value_B[WIDTH-1]) ? -value_B : value_B;

  // Extra top bit acts as the borrow: set means the shifted remainder is below the divisor.
  assign trial = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvsr_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    a_d        = a_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    low_d      = low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dz_d       = dz_q;

    case (state_q)
      StIdle: begin
        if (divInit) begin
          a_d        = value_A;
          neg_quot_d = is_signed & (value_A[WIDTH-1] ^ value_B[WIDTH-1]);
          neg_rem_d  = is_signed & value_A[WIDTH-1];
          dz_d       = 1'b0;
          busy_d     = 1'b1;
          if (value_B == '0) begin
            state_d = StZero;
          end else begin
            rem_d   = '0;
            quot_d  = a_mag;
            dvsr_d  = b_mag;
            cnt_d   = CntW'(WIDTH);
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (!trial[WIDTH]) begin
          rem_d  = trial[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end

      StFix: begin
        low_d   = neg_quot_q ? -quot_q : quot_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      StZero: begin
        hi_d    = a_q;
        low_d   = '1;
        dz_d    = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      a_q        <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      low_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      a_q        <= a_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      low_q      <= low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign low      = low_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: 32-bit and 8-bit instances checked against an arithmetic model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        init32, s32, busy32, done32, dz32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        init8, s8, busy8, done8, dz8;
  logic [7:0]  a8, b8, hi8, lo8;

  div_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .divInit(init32), .is_signed(s32), .value_A(a32),
    .value_B(b32), .hi(hi32), .low(lo32), .busy(busy32), .done(done32), .div_zero(dz32)
  );

  div_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .divInit(init8), .is_signed(s8), .value_A(a8),
    .value_B(b8), .hi(hi8), .low(lo8), .busy(busy8), .done(done8), .div_zero(dz8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    bit          z;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain truncating division on sign/zero-extended 64-bit integers.
  function automatic exp_t model(int w, bit s, logic [63:0] a, logic [63:0] b);
    exp_t        e;
    logic [63:0] mask;
    longint      sa, sb;
    mask  = (64'd1 << w) - 64'd1;
    e.acc = 0;
    e.lat = w + 1;
    e.z   = 1'b0;
    if ((b & mask) == 64'd0) begin
      e.q   = mask;
      e.r   = a & mask;
      e.z   = 1'b1;
      e.lat = 1;
      return e;
    end
    if (s) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
    end else begin
      sa = longint'(a & mask);
      sb = longint'(b & mask);
    end
    e.q = 64'(sa / sb) & mask;
    e.r = 64'(sa % sb) & mask;
    return e;
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!reset) begin
      if (done32) begin
        chk("w32 busy_with_done", 64'(busy32), 64'd0);
        if (sb32.size() == 0) begin
          chk("w32 unexpected_done", 64'(done32), 64'd0);
        end else begin
          e = sb32.pop_front();
          chk("w32 low", 64'(lo32), e.q);
          chk("w32 hi", 64'(hi32), e.r);
          chk("w32 div_zero", 64'(dz32), 64'(e.z));
          chk("w32 latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end else if (sb32.size() != 0) begin
        chk("w32 busy", 64'(busy32), 64'd1);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!reset) begin
      if (done8) begin
        chk("w8 busy_with_done", 64'(busy8), 64'd0);
        if (sb8.size() == 0) begin
          chk("w8 unexpected_done", 64'(done8), 64'd0);
        end else begin
          e = sb8.pop_front();
          chk("w8 low", 64'(lo8), e.q);
          chk("w8 hi", 64'(hi8), e.r);
          chk("w8 div_zero", 64'(dz8), 64'(e.z));
          chk("w8 latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end else if (sb8.size() != 0) begin
        chk("w8 busy", 64'(busy8), 64'd1);
      end
    end
  end

  // use_k selects hand-derived expected values instead of the model.
  task automatic issue(int w, bit s, logic [63:0] a, logic [63:0] b, bit wait_edge, bit use_k,
                       logic [63:0] kq, logic [63:0] kr, bit kz);
    exp_t e;
    if (wait_edge) @(negedge clk);
    if (w == 32) begin
      s32 = s; a32 = a[31:0]; b32 = b[31:0]; init32 = 1'b1;
    end else begin
      s8 = s; a8 = a[7:0]; b8 = b[7:0]; init8 = 1'b1;
    end
    @(posedge clk);
    #1;
    init32 = 1'b0;
    init8  = 1'b0;
    e = model(w, s, a, b);
    if (use_k) begin
      e.q = kq; e.r = kr; e.z = kz;
    end
    e.acc = cyc;
    if (w == 32) begin
      sb32.push_back(e);
      chk("w32 busy_at_accept", 64'(busy32), 64'd1);
      chk("w32 dz_clear_at_accept", 64'(dz32), 64'd0);
    end else begin
      sb8.push_back(e);
      chk("w8 busy_at_accept", 64'(busy8), 64'd1);
      chk("w8 dz_clear_at_accept", 64'(dz8), 64'd0);
    end
  endtask

  task automatic wait_idle(int w);
    int sz;
    for (int i = 0; i < 200; i++) begin
      sz = (w == 32) ? sb32.size() : sb8.size();
      if (sz == 0) break;
      @(negedge clk);
    end
    sz = (w == 32) ? sb32.size() : sb8.size();
    if (sz != 0) begin
      chk("done_timeout", 64'(sz), 64'd0);
      if (w == 32) sb32.delete();
      else sb8.delete();
    end
  endtask

  task automatic chk_zero32(string tag);
    chk({tag, " hi"}, 64'(hi32), 64'd0);
    chk({tag, " low"}, 64'(lo32), 64'd0);
    chk({tag, " busy"}, 64'(busy32), 64'd0);
    chk({tag, " done"}, 64'(done32), 64'd0);
    chk({tag, " div_zero"}, 64'(dz32), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    int          w;
    bit          s;
    int          sel;
    bit          seen;

    reset = 1'b1;
    init32 = 1'b0; s32 = 1'b0; a32 = '0; b32 = '0;
    init8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero32("reset32");
    chk("reset8 hi", 64'(hi8), 64'd0);
    chk("reset8 low", 64'(lo8), 64'd0);
    chk("reset8 busy", 64'(busy8), 64'd0);
    reset = 1'b0;

    issue(32, 0, 100, 7, 1, 1, 14, 2, 0);                                  wait_idle(32);
    issue(32, 1, 'hFFFFFFF9, 2, 1, 1, 'hFFFFFFFD, 'hFFFFFFFF, 0);          wait_idle(32);
    issue(32, 0, 'hFFFFFFF9, 2, 1, 1, 'h7FFFFFFC, 1, 0);                   wait_idle(32);
    issue(32, 1, 'h80000000, 'hFFFFFFFF, 1, 1, 'h80000000, 0, 0);          wait_idle(32);
    issue(32, 0, 'hFFFFFFFF, 1, 1, 1, 'hFFFFFFFF, 0, 0);                   wait_idle(32);
    issue(32, 0, 'h1234, 0, 1, 1, 'hFFFFFFFF, 'h1234, 1);                  wait_idle(32);

    // Request while running must be ignored.
    issue(32, 0, 1000, 7, 1, 1, 142, 6, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a32 = 5; b32 = 1; init32 = 1'b1;
    @(posedge clk);
    #1;
    init32 = 1'b0;
    wait_idle(32);

    // Reset at iteration 10 aborts the op with no done pulse.
    issue(32, 0, 500, 9, 1, 0, 0, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb32.delete();
    reset = 1'b0;
    chk_zero32("midrun_reset");
    repeat (40) @(negedge clk);
    issue(32, 0, 9, 3, 1, 1, 3, 0, 0);                                     wait_idle(32);

    // Reset wins over a simultaneous request.
    @(negedge clk);
    reset = 1'b1; init32 = 1'b1; a32 = 50; b32 = 5;
    @(posedge clk);
    #1;
    reset = 1'b0; init32 = 1'b0;
    chk("reset_vs_init busy", 64'(busy32), 64'd0);
    @(posedge clk);
    #1;
    chk("reset_vs_init busy_later", 64'(busy32), 64'd0);
    repeat (40) @(negedge clk);

    issue(8, 0, 200, 3, 1, 1, 66, 2, 0);                                   wait_idle(8);
    issue(8, 1, 'h80, 3, 1, 1, 'hD6, 'hFE, 0);                             wait_idle(8);

    // Back-to-back: second accepted in the done cycle of the first.
    issue(8, 0, 250, 7, 1, 1, 35, 5, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        break;
      end
    end
    chk("w8 b2b first_done_seen", 64'(seen), 64'd1);
    issue(8, 1, 'hF0, 5, 0, 1, 'hFD, 'hFF, 0);
    wait_idle(8);

    for (int i = 0; i < 60; i++) begin
      w   = (i % 2 == 1) ? 32 : 8;
      s   = 1'($urandom % 2);
      ra  = {32'($urandom), 32'($urandom)};
      if ($urandom % 8 == 0) ra = 64'd1 << (w - 1);
      sel = int'($urandom % 8);
      case (sel)
        0:       rb = 64'd0;
        1:       rb = 64'd1;
        2:       rb = '1;
        3:       rb = 64'($urandom % 16);
        default: rb = {32'($urandom), 32'($urandom)};
      endcase
      issue(w, s, ra, rb, 1, 0, 0, 0, 0);
      wait_idle(w);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised multi-cycle integer divider for the datapath's hi/low result pair. It produces a quotient on `low` and a remainder on `hi` using restoring division at one quotient bit per cycle. It supports signed and unsigned modes and flags divide-by-zero. Handshake is start/busy/done, so the control unit can stall on `busy` or wait for the `done` pulse.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width; legal range ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `divInit`  in  1  start request; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; captured with `divInit`.
- `value_A`  in  WIDTH  dividend; captured with `divInit`.
- `value_B`  in  WIDTH  divisor; captured with `divInit`.
- `hi`  out  WIDTH  remainder.
- `low`  out  WIDTH  quotient.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; results valid.
- `div_zero`  out  1  last accepted operation had divisor 0.

## Operation
- FSM states: IDLE, RUN, FIX, ZERO.
- IDLE with `divInit`=1 (accept):
  - Capture operands, mode, and operand signs.
  - Clear `div_zero`.
  - If `value_B`==0, go to ZERO.
  - Otherwise load |A| into the dividend/quotient shift register, |B| into the divisor register, clear the partial remainder, set counter=WIDTH, go to RUN.
  - Magnitudes are taken only when `is_signed`=1; unsigned operands are used as-is.
- RUN, each cycle:
  - Shift {rem, quot} left by 1; trial = rem − divisor (WIDTH+1 bits).
  - If trial ≥ 0: rem = trial, quotient LSB = 1; else quotient LSB = 0.
  - Decrement counter; at counter reaching 0, go to FIX.
- FIX (signed mode only applies signs):
  - Quotient is negated if sign(A) ≠ sign(B).
  - Remainder is negated if A negative.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Write `hi`/`low`, pulse `done`, go to IDLE.
- ZERO: `hi`=value_A as captured, `low`=all ones, `div_zero`=1, pulse `done`, go to IDLE.
- Signed MIN / −1: `low`=MIN (wraps), `hi`=0, no flag.
- `divInit` while not in IDLE is ignored, with no queueing. Inputs may change freely after acceptance.
- `hi`, `low`, `div_zero` hold their values until the next completion or reset. `div_zero` additionally clears on accept.

## Timing
- Edge 0 is the edge that samples `divInit`=1 in IDLE.
- Normal path:
  - Edges 1..WIDTH perform the iterations.
  - Edge WIDTH+1 writes results and sets `done`=1.
  - `done` returns to 0 after edge WIDTH+2.
- Divide-by-zero: results and `done`=1 at edge 1; `done` low after edge 2.
- `busy`:
  - Set at edge 0.
  - Cleared at the same edge that sets `done`, so `busy` and `done` are never high together.
- A new `divInit` can be accepted in the `done` cycle, giving back-to-back operations with a WIDTH+2-cycle period.
- Reset, any state including mid-RUN:
  - Next edge: state IDLE; `hi`, `low`, counter and internal registers = 0; `busy`=`done`=`div_zero`=0.
  - No `done` pulse for the aborted operation.
- `reset` and `divInit` high on the same edge: reset wins, and the request is dropped.

## Test plan
- WIDTH=32, unsigned 100 / 7 → `low`=14, `hi`=2; `done` high exactly one cycle after edge 33; `busy` high edges 0..32.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) → `low`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Same operands unsigned → `low`=0x7FFFFFFC, `hi`=1.
- Signed 0x80000000 / 0xFFFFFFFF → `low`=0x80000000, `hi`=0, `div_zero`=0. Unsigned 0xFFFFFFFF / 1 → `low`=0xFFFFFFFF, `hi`=0.
- Divide by zero: A=0x1234, B=0 → `done` after edge 1, `div_zero`=1, `hi`=0x1234, `low`=0xFFFFFFFF. Next normal op clears `div_zero` at its accept.
- Operation in flight:
  - Re-pulse `divInit` with new operands at edge 5 → ignored; original result is returned.
  - Then assert `reset` at iteration 10 of a second op → all outputs 0 next cycle, no `done`.
  - New op 9/3 afterwards → `low`=3, `hi`=0.
- WIDTH=8 instance:
  - Unsigned 200 / 3 → `low`=66, `hi`=2, `done` after edge 9.
  - Signed −128 / 3 → `low`=0xD6 (−42), `hi`=0xFE (−2).
  - Back-to-back accept in the `done` cycle → second result after 10 more edges.
